// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   - Encodings of the 2-bit saturating direction counters.
//   - Reset state of every BHT entry.
//   - Position of the lowest PC bit used for indexing. Instructions are
//     word aligned, so bits [1:0] never select an entry.
package bp_pkg;

   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   localparam logic [1:0] BHT_RESET_STATE = WEAK_NT;

   // The BHT index starts at this PC bit: idx = pc[INDEX_BITS+IDX_LSB-1:IDX_LSB]
   localparam int IDX_LSB = 2;

   // The predicted direction of a counter is its MSB (1 = taken).
   function automatic logic counter_dir(input logic [1:0] state);
      return state[1];
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Purely combinational.
// Ports:
//   state      - current counter value
//   taken      - resolved branch outcome (1 = taken)
//   next_state - counter value after training: incremented on taken,
//                decremented on not-taken, clamped at STRONG_T and STRONG_NT
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] state,
   input  logic       taken,
   output logic [1:0] next_state
);

   always_comb begin
      next_state = state;
      if (taken) begin
         if (state != STRONG_T) next_state = state + 2'd1;
      end else begin
         if (state != STRONG_NT) next_state = state - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direct-mapped table of 2-bit saturating counters
// (the BHT), indexed by PC bits [INDEX_BITS+1:2]. There are no tags, so
// aliasing is allowed.
//
// Ports:
//   clk, arst_n      - clock (rising edge) and asynchronous active-low reset
//   enable           - pipeline advance; 0 holds the prediction register
//   flush_if         - IF/ID flush; clears the prediction register (wins over enable)
//   if_pc            - fetch PC used for the lookup
//   prediction       - registered direction for the instruction now in ID
//   upd_valid/upd_pc/upd_taken/upd_predicted - branch resolution from EX
//   mispredict       - combinational: upd_valid & (upd_taken != upd_predicted)
//   stat_branches    - saturating count of resolved branches
//   stat_mispredicts - saturating count of mispredictions
//
// The update channel has valid-only semantics. There is no ready signal: the
// table accepts a resolution on every rising edge where upd_valid=1, whatever
// enable and flush_if are doing. At most one update arrives per cycle.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int PC_WIDTH   = 64,
   parameter int INDEX_BITS = 6,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic                  flush_if,
   input  logic [PC_WIDTH-1:0]   if_pc,
   output logic                  prediction,
   input  logic                  upd_valid,
   input  logic [PC_WIDTH-1:0]   upd_pc,
   input  logic                  upd_taken,
   input  logic                  upd_predicted,
   output logic                  mispredict,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   // The BHT is a flop array so that every entry can be reset asynchronously.
   logic [1:0]            bht [ENTRIES];
   logic [INDEX_BITS-1:0] lookup_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [1:0]            upd_state;
   logic [1:0]            upd_next;

   assign lookup_idx = if_pc[INDEX_BITS+IDX_LSB-1:IDX_LSB];
   assign upd_idx    = upd_pc[INDEX_BITS+IDX_LSB-1:IDX_LSB];
   assign upd_state  = bht[upd_idx];

   // The upper PC bits and the byte offset take no part in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:INDEX_BITS+IDX_LSB], if_pc[IDX_LSB-1:0],
                             upd_pc[PC_WIDTH-1:INDEX_BITS+IDX_LSB], upd_pc[IDX_LSB-1:0]};

   sat_counter2 u_upd_counter (
      .state      (upd_state),
      .taken      (upd_taken),
      .next_state (upd_next)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= BHT_RESET_STATE;
      end else if (upd_valid) begin
         bht[upd_idx] <= upd_next;
      end
   end

   // The lookup reads bht before the same edge's update lands. That gives
   // read-before-write behaviour when the lookup and update hit the same entry.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)       prediction <= 1'b0;
      else if (flush_if) prediction <= 1'b0;
      else if (enable)   prediction <= counter_dir(bht[lookup_idx]);
   end

   assign mispredict = upd_valid & (upd_taken != upd_predicted);

   // Both counters stop at all-ones and never wrap.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid && (stat_branches != {STAT_WIDTH{1'b1}}))
            stat_branches <= stat_branches + STAT_WIDTH'(1);
         if (mispredict && (stat_mispredicts != {STAT_WIDTH{1'b1}}))
            stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int PC_WIDTH   = 64;
   localparam int INDEX_BITS = 6;
   localparam int STAT_WIDTH = 32;
   localparam int ENTRIES    = 1 << INDEX_BITS;
   localparam longint STAT_MAX = (64'd1 << STAT_WIDTH) - 1;

   logic                  clk;
   logic                  arst_n;
   logic                  enable;
   logic                  flush_if;
   logic [PC_WIDTH-1:0]   if_pc;
   logic                  prediction;
   logic                  upd_valid;
   logic [PC_WIDTH-1:0]   upd_pc;
   logic                  upd_taken;
   logic                  upd_predicted;
   logic                  mispredict;
   logic [STAT_WIDTH-1:0] stat_branches;
   logic [STAT_WIDTH-1:0] stat_mispredicts;

   int tests_run = 0;
   int tests_failed = 0;

   branch_predictor #(
      .PC_WIDTH   (PC_WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .STAT_WIDTH (STAT_WIDTH)
   ) dut (
      .clk              (clk),
      .arst_n           (arst_n),
      .enable           (enable),
      .flush_if         (flush_if),
      .if_pc            (if_pc),
      .prediction       (prediction),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_predicted    (upd_predicted),
      .mispredict       (mispredict),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input longint actual, input longint expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Counters are kept as plain integers 0..3. An entry predicts taken when
   // its counter is 2 or more.
   int     m_ctr [ENTRIES];
   logic   m_pred = 1'b0;
   longint m_br   = 0;
   longint m_mp   = 0;

   initial for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;

   function automatic int idx_of(input logic [PC_WIDTH-1:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
         m_pred = 1'b0;
         m_br   = 0;
         m_mp   = 0;
      end else begin
         // The lookup sees the table as it was before this edge's update.
         if (flush_if)    m_pred = 1'b0;
         else if (enable) m_pred = (m_ctr[idx_of(if_pc)] >= 2);
         if (upd_valid) begin
            if (upd_taken) m_ctr[idx_of(upd_pc)] = (m_ctr[idx_of(upd_pc)] == 3) ? 3 : m_ctr[idx_of(upd_pc)] + 1;
            else           m_ctr[idx_of(upd_pc)] = (m_ctr[idx_of(upd_pc)] == 0) ? 0 : m_ctr[idx_of(upd_pc)] - 1;
            if (m_br < STAT_MAX) m_br = m_br + 1;
            if (upd_taken != upd_predicted && m_mp < STAT_MAX) m_mp = m_mp + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("cyc_prediction", longint'(prediction), longint'(m_pred));
      check("cyc_mispredict", longint'(mispredict),
            longint'(upd_valid && (upd_taken != upd_predicted)));
      check("cyc_stat_branches", longint'(stat_branches), m_br);
      check("cyc_stat_mispredicts", longint'(stat_mispredicts), m_mp);
   end

   // ---------------- driver ----------------
   task automatic step(input logic en, input logic fl, input logic [PC_WIDTH-1:0] pc,
                       input logic uv, input logic [PC_WIDTH-1:0] upc,
                       input logic ut, input logic up);
      enable        = en;
      flush_if      = fl;
      if_pc         = pc;
      upd_valid     = uv;
      upd_pc        = upc;
      upd_taken     = ut;
      upd_predicted = up;
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [PC_WIDTH-1:0] pc);
      step(1'b1, 1'b0, pc, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic train(input logic [PC_WIDTH-1:0] pc, input logic [PC_WIDTH-1:0] upc,
                        input logic ut, input logic up);
      step(1'b1, 1'b0, pc, 1'b1, upc, ut, up);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      enable = 1'b0; flush_if = 1'b0; if_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_predicted = 1'b0;
      arst_n = 1'b1;
      #3 arst_n = 1'b0;
      #10 arst_n = 1'b1;

      // Reset state
      check("reset_prediction", longint'(prediction), 0);
      check("reset_stat_branches", longint'(stat_branches), 0);
      check("reset_stat_mispredicts", longint'(stat_mispredicts), 0);
      lookup(64'h100);
      check("reset_lookup_0x100", longint'(prediction), 0);

      // Training: 01 -> 10 -> 11 -> 11. upd_predicted follows the table, so
      // only the first update mispredicts.
      train(64'h104, 64'h100, 1'b1, 1'b0);
      train(64'h104, 64'h100, 1'b1, 1'b1);
      check("train_no_mispredict", longint'(mispredict), 0);
      train(64'h104, 64'h100, 1'b1, 1'b1);
      lookup(64'h100);
      check("train_lookup_0x100", longint'(prediction), 1);
      check("train_stat_branches", longint'(stat_branches), 3);
      check("train_stat_mispredicts", longint'(stat_mispredicts), 1);

      // Aliasing: 0x200 shares idx 0. 0x104 is idx 1 and was never trained.
      lookup(64'h200);
      check("alias_lookup_0x200", longint'(prediction), 1);
      lookup(64'h104);
      check("index_lookup_0x104", longint'(prediction), 0);

      // Stall holds, and flush clears even with enable=1
      lookup(64'h100);
      check("pre_stall_prediction", longint'(prediction), 1);
      step(1'b0, 1'b0, 64'h104, 1'b0, '0, 1'b0, 1'b0);
      check("stall1_hold", longint'(prediction), 1);
      step(1'b0, 1'b0, 64'h104, 1'b0, '0, 1'b0, 1'b0);
      check("stall2_hold", longint'(prediction), 1);
      step(1'b1, 1'b1, 64'h100, 1'b0, '0, 1'b0, 1'b0);
      check("flush_clears", longint'(prediction), 0);

      // Hysteresis: 11 -> 10 still predicts taken, then 10 -> 01 predicts not taken
      train(64'h100, 64'h100, 1'b0, 1'b1);
      check("hyst_mispredict_comb", longint'(mispredict), 1);
      check("hyst_pre_update_read", longint'(prediction), 1);
      lookup(64'h100);
      check("hyst_weak_t_predicts_1", longint'(prediction), 1);
      train(64'h104, 64'h100, 1'b0, 1'b1);
      lookup(64'h100);
      check("hyst_weak_nt_predicts_0", longint'(prediction), 0);

      // Collision: lookup and update on idx 0 in the same cycle, entry at 01
      train(64'h100, 64'h100, 1'b1, 1'b0);
      check("collision_reads_old", longint'(prediction), 0);
      lookup(64'h100);
      check("collision_update_committed", longint'(prediction), 1);
      check("collision_stat_branches", longint'(stat_branches), 6);
      check("collision_stat_mispredicts", longint'(stat_mispredicts), 4);

      // Asynchronous reset mid-run, away from any clock edge
      #2 arst_n = 1'b0;
      #1;
      check("async_reset_prediction", longint'(prediction), 0);
      check("async_reset_stat_branches", longint'(stat_branches), 0);
      check("async_reset_stat_mispredicts", longint'(stat_mispredicts), 0);
      @(negedge clk);
      #1 arst_n = 1'b1;
      lookup(64'h100);
      check("post_reset_history_gone", longint'(prediction), 0);
      lookup(64'h104);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
